// File: rtl/unlock_if.sv
// Status/control bundle between the access controller and the board I/O.
interface unlock_if;
  logic       check;
  logic       match;
  logic       open;
  logic       alarm;
  logic [1:0] tries_left;
  logic [6:0] seg;
  logic       r_led;
  logic       g_led;
  logic       b_led;

  modport slave (
    input  check, match,
    output open, alarm, tries_left, seg, r_led, g_led, b_led
  );

  modport master (
    output check, match,
    input  open, alarm, tries_left, seg, r_led, g_led, b_led
  );
endinterface

// File: rtl/unlock_ctrl.sv
// Open/deny decision, failed-attempt counting and timed lockout with a
// seconds countdown on one seven-segment digit plus status LED and alarm.
module unlock_ctrl #(
  parameter int unsigned TICK_DIV  = 1_000_000,
  parameter int unsigned MAX_TRIES = 3,
  parameter int unsigned OPEN_SEC  = 5,
  parameter int unsigned LOCK_SEC  = 9
) (
  input  logic     clk,
  input  logic     rst_n,
  unlock_if.slave  bus
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OPEN    = 2'd1,
    S_LOCKOUT = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     fail_q, fail_d;
  logic [3:0]     timer_q, timer_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic           check_q;
  logic           open_q, open_d;
  logic           alarm_q, alarm_d;
  logic [1:0]     tries_q, tries_d;
  logic [6:0]     seg_q, seg_d;
  logic           r_q, r_d;
  logic           g_q, g_d;
  logic           b_q, b_d;
  logic           att_c;
  logic           tick_c;
  logic [2:0]     fail_inc_c;

  // Digit 0..9 to active-high a..g pattern (bit0 = a).
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  // State register, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      fail_q  <= 2'd0;
      timer_q <= 4'd0;
      presc_q <= '0;
      check_q <= 1'b1;
      open_q  <= 1'b0;
      alarm_q <= 1'b0;
      tries_q <= 2'(MAX_TRIES);
      seg_q   <= 7'h00;
      r_q     <= 1'b0;
      g_q     <= 1'b0;
      b_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
      timer_q <= timer_d;
      presc_q <= presc_d;
      check_q <= bus.check;
      open_q  <= open_d;
      alarm_q <= alarm_d;
      tries_q <= tries_d;
      seg_q   <= seg_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  // Next-state logic; outputs are derived from the next state so they
  // change on the same edge that takes the attempt or tick.
  always_comb begin
    state_d    = state_q;
    fail_d     = fail_q;
    timer_d    = timer_q;
    presc_d    = '0;
    att_c      = bus.check & ~check_q;
    tick_c     = (state_q != S_IDLE) && (presc_q == PW'(TICK_DIV - 1));
    fail_inc_c = {1'b0, fail_q} + 3'd1;

    case (state_q)
      S_IDLE: begin
        if (att_c) begin
          if (bus.match) begin
            state_d = S_OPEN;
            timer_d = 4'(OPEN_SEC);
            fail_d  = 2'd0;
          end else if (fail_inc_c < 3'(MAX_TRIES)) begin
            fail_d  = fail_inc_c[1:0];
          end else begin
            state_d = S_LOCKOUT;
            timer_d = 4'(LOCK_SEC);
            fail_d  = 2'd0;
          end
        end
      end
      S_OPEN, S_LOCKOUT: begin
        presc_d = tick_c ? '0 : PW'(presc_q + 1'b1);
        if (tick_c) begin
          if (timer_q == 4'd1) begin
            timer_d = 4'd0;
            state_d = S_IDLE;
          end else begin
            timer_d = timer_q - 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every state entry restarts a full second.
    if (state_d != state_q) presc_d = '0;

    open_d  = (state_d == S_OPEN);
    alarm_d = (state_d == S_LOCKOUT);
    tries_d = 2'(MAX_TRIES) - fail_d;
    seg_d   = (state_d == S_IDLE) ? 7'h00 : seg_decode(timer_d);
    r_d     = 1'b0;
    g_d     = 1'b0;
    b_d     = 1'b0;
    case (state_d)
      S_OPEN:    g_d = 1'b1;
      S_LOCKOUT: r_d = (state_q != S_LOCKOUT) ? 1'b1 : (tick_c ? ~r_q : r_q);
      default:   b_d = 1'b1;
    endcase
  end

  assign bus.open       = open_q;
  assign bus.alarm      = alarm_q;
  assign bus.tries_left = tries_q;
  assign bus.seg        = seg_q;
  assign bus.r_led      = r_q;
  assign bus.g_led      = g_q;
  assign bus.b_led      = b_q;

endmodule

// File: doc/unlock_ctrl.md
# unlock_ctrl

Access controller that sits directly downstream of `secret_box`. It consumes the debounced "check" button level and the code-match flag, and decides open/deny. It counts failed attempts and enforces a timed lockout after too many failures, showing the remaining seconds on a single seven-segment digit. It also drives a status RGB LED and an alarm line for the board.

## Interface
Parameters:
- `TICK_DIV`, 1_000_000, clk cycles per one-second tick (≥2)
- `MAX_TRIES`, 3, failed attempts before lockout (1..3)
- `OPEN_SEC`, 5, seconds the box stays open (1..9)
- `LOCK_SEC`, 9, lockout duration in seconds (1..9)

Ports:
- `clk`  in  1  system clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `check`  in  1  debounced button level; a rising edge is one attempt
- `match`  in  1  high when the entered code equals the stored code; sampled only on a check edge
- `open`  out  1  high while in OPEN
- `alarm`  out  1  high while in LOCKOUT
- `tries_left`  out  2  remaining attempts before lockout
- `seg`  out  7  active-high segments, bit0=a … bit6=g; digit = remaining seconds
- `r_led`, `g_led`, `b_led`  out  1 each  status LED

## Operation
- States: IDLE, OPEN, LOCKOUT.
- Reset values: state IDLE, `fail_cnt`=0, `timer`=0, prescaler=0, `check_d`=1.
- Output reset values: `open`=0, `alarm`=0, `tries_left`=MAX_TRIES, `seg`=7'h00, `r_led`=0, `g_led`=0, `b_led`=1.
- Edge detect: `att = check & ~check_d`.
  - `check_d` resets to 1, so a button already held through reset does not count as an attempt.
  - Holding the button produces exactly one attempt.
- IDLE, on `att`:
  - `match`=1: go to OPEN, `timer`=OPEN_SEC, `fail_cnt`=0.
  - `match`=0 and `fail_cnt+1`<MAX_TRIES: `fail_cnt`+=1, stay in IDLE.
  - `match`=0 and `fail_cnt+1`==MAX_TRIES: go to LOCKOUT, `timer`=LOCK_SEC, `fail_cnt`=0.
- OPEN and LOCKOUT:
  - `att` is ignored; `check_d` still tracks `check`.
  - On each tick `timer` decrements.
  - A tick taken while `timer`==1 sets `timer`=0 and returns to IDLE.
- Prescaler:
  - Counts 0..TICK_DIV-1; a tick occurs on the cycle it reaches TICK_DIV-1, and it then wraps to 0.
  - It is cleared to 0 on every state entry, so the first second after entry is a full TICK_DIV cycles.
  - It is held at 0 while in IDLE.
- `tries_left` = MAX_TRIES − `fail_cnt`. It shows MAX_TRIES in OPEN and LOCKOUT because `fail_cnt` is cleared on entry.
- `seg`: hex-free decode of `timer` 0..9 (standard a–g patterns) in OPEN and LOCKOUT; 7'h00 in IDLE.
- LED:
  - IDLE: blue (0,0,1).
  - OPEN: green (0,1,0).
  - LOCKOUT: `r_led` starts at 1 on entry and toggles on every tick; `g_led`=`b_led`=0.
- Reset mid-operation: asserting `rst_n` asynchronously forces all reset values, aborts any OPEN or LOCKOUT, and clears the failure count.

## Timing
- All outputs are registered. They update on the same clock edge that samples the attempt (`check`=1, `check_d`=0) or the tick.
- Latency from `check` rising to `open`/`alarm`/`tries_left` changing: 1 clock edge.
- OPEN lasts exactly OPEN_SEC×TICK_DIV cycles; LOCKOUT lasts exactly LOCK_SEC×TICK_DIV cycles.
- An attempt arriving on the same edge as the final tick is ignored. The state is still OPEN/LOCKOUT on that edge; a fresh rising edge is required afterwards.
- `match` has no timing requirement outside attempt edges.

## Test plan
All scenarios use TICK_DIV=4, MAX_TRIES=3, OPEN_SEC=2, LOCK_SEC=3.
- Reset with `check`=1 held, release `rst_n`, keep `check` high for 20 cycles -> state stays IDLE, `tries_left`=3, `b_led`=1, `seg`=0.
- `match`=1, one `check` pulse -> next edge: `open`=1, `g_led`=1, `seg`=7'h5B ("2"); after 4 cycles `seg`=7'h06 ("1"); after 8 cycles total `open`=0, `b_led`=1, `seg`=0.
- Two `check` pulses with `match`=0 -> `tries_left` 3→2→1. Then one pulse with `match`=1 -> OPEN, and `tries_left`=3 after the box closes.
- Three failed pulses -> `alarm`=1, `r_led`=1, `seg`=7'h4F ("3"). `r_led` toggles every 4 cycles. Extra pulses (with `match`=1) during lockout cause no change. IDLE returns after exactly 12 cycles with `tries_left`=3.
- Enter OPEN, then assert `rst_n`=0 mid-second -> all outputs go to reset values immediately, without waiting for a clock edge.
- Hold `check` high across an OPEN→IDLE return -> no new attempt. A release then re-press counts as one attempt.
